// File: rtl/icb_arb_pkg.sv
// Shared constants for the ICB debug arbiter: master IDs, default outstanding depth and a
// constant-safe ceil(log2) helper.
package icb_arb_pkg;

  localparam logic ID_CORE = 1'b0;
  localparam logic ID_DBG  = 1'b1;

  localparam int unsigned DEF_OUTS_DEPTH = 4;

  // ceil(log2(v)), usable in parameter expressions
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/icb_arb_id_fifo.sv
// In-order 1-bit ID FIFO recording which master issued each outstanding command.
// Push is ignored when full, pop is ignored when empty.
module icb_arb_id_fifo
  import icb_arb_pkg::*;
#(
  parameter int unsigned Depth = DEF_OUTS_DEPTH,
  localparam int unsigned PtrW = clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push_i,
  input  logic            id_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic            head_o,
  output logic [CntW-1:0] count_o
);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state: pointers wrap naturally since Depth is a power of two
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = id_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/icb_dbg_arbiter.sv
// 2:1 ICB arbiter: core LSU (m0) and debug jtag2icb (m1) share one system-bus slave port.
// Commands pass through combinationally; an ID FIFO routes in-order responses back.
// Build option: define ICB_ARB_RR_EN for round-robin, otherwise m1 has fixed priority.
module icb_dbg_arbiter
  import icb_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned OUTS_DEPTH = DEF_OUTS_DEPTH
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            m0_cmd_valid,
  output logic            m0_cmd_ready,
  input  logic [AW-1:0]   m0_cmd_addr,
  input  logic [DW-1:0]   m0_cmd_wdata,
  input  logic            m0_cmd_read,
  input  logic [DW/8-1:0] m0_cmd_wmask,
  output logic            m0_rsp_valid,
  input  logic            m0_rsp_ready,
  output logic [DW-1:0]   m0_rsp_rdata,
  output logic            m0_rsp_err,
  input  logic            m1_cmd_valid,
  output logic            m1_cmd_ready,
  input  logic [AW-1:0]   m1_cmd_addr,
  input  logic [DW-1:0]   m1_cmd_wdata,
  input  logic            m1_cmd_read,
  input  logic [DW/8-1:0] m1_cmd_wmask,
  output logic            m1_rsp_valid,
  input  logic            m1_rsp_ready,
  output logic [DW-1:0]   m1_rsp_rdata,
  output logic            m1_rsp_err,
  output logic            s_cmd_valid,
  input  logic            s_cmd_ready,
  output logic [AW-1:0]   s_cmd_addr,
  output logic [DW-1:0]   s_cmd_wdata,
  output logic            s_cmd_read,
  output logic [DW/8-1:0] s_cmd_wmask,
  input  logic            s_rsp_valid,
  output logic            s_rsp_ready,
  input  logic [DW-1:0]   s_rsp_rdata,
  input  logic            s_rsp_err,
  output logic            arb_busy
);

  localparam int unsigned CntW = clog2(OUTS_DEPTH) + 1;

  logic            lock_q, lock_d, lock_id_q, lock_id_d;
  logic            gnt_vld, gnt_id, both_pick, cmd_hs;
  logic            fifo_full, fifo_empty, fifo_head, fifo_pop;
  logic [CntW-1:0] fifo_count;

`ifdef ICB_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // Round-robin pointer follows every accepted command
  always_comb begin
    last_grant_d = cmd_hs ? gnt_id : last_grant_q;
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_grant_q <= ID_CORE;
    else       last_grant_q <= last_grant_d;
  end

  assign both_pick = ~last_grant_q;
`else
  assign both_pick = ID_DBG;
`endif

  // Grant: a stalled command owns the slave until it handshakes; nothing issues while full
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = ID_CORE;
    if (lock_q) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id_q;
    end else if (!fifo_full) begin
      if (m0_cmd_valid && m1_cmd_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = both_pick;
      end else if (m1_cmd_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_DBG;
      end else if (m0_cmd_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_CORE;
      end
    end
  end

  assign s_cmd_valid  = gnt_vld;
  assign s_cmd_addr   = (gnt_id == ID_DBG) ? m1_cmd_addr  : m0_cmd_addr;
  assign s_cmd_wdata  = (gnt_id == ID_DBG) ? m1_cmd_wdata : m0_cmd_wdata;
  assign s_cmd_read   = (gnt_id == ID_DBG) ? m1_cmd_read  : m0_cmd_read;
  assign s_cmd_wmask  = (gnt_id == ID_DBG) ? m1_cmd_wmask : m0_cmd_wmask;
  assign cmd_hs       = s_cmd_valid && s_cmd_ready;
  assign m0_cmd_ready = gnt_vld && (gnt_id == ID_CORE) && s_cmd_ready;
  assign m1_cmd_ready = gnt_vld && (gnt_id == ID_DBG) && s_cmd_ready;

  // Lock next-state: hold the granted master while the slave back-pressures
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (s_cmd_valid && !s_cmd_ready) begin
      lock_d    = 1'b1;
      lock_id_d = gnt_id;
    end else if (cmd_hs) begin
      lock_d = 1'b0;
    end
  end

  // Lock registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_q    <= 1'b0;
      lock_id_q <= ID_CORE;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  icb_arb_id_fifo #(
    .Depth (OUTS_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (cmd_hs),
    .id_i    (gnt_id),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  // Response demux: only the head master sees the response; stray responses stall
  assign m0_rsp_valid = s_rsp_valid && !fifo_empty && (fifo_head == ID_CORE);
  assign m1_rsp_valid = s_rsp_valid && !fifo_empty && (fifo_head == ID_DBG);
  assign s_rsp_ready  = !fifo_empty &&
                        ((fifo_head == ID_DBG) ? m1_rsp_ready : m0_rsp_ready);
  assign fifo_pop     = s_rsp_valid && s_rsp_ready;
  assign m0_rsp_rdata = s_rsp_rdata;
  assign m1_rsp_rdata = s_rsp_rdata;
  assign m0_rsp_err   = s_rsp_err;
  assign m1_rsp_err   = s_rsp_err;

  assign arb_busy = (fifo_count != '0) || lock_q;

endmodule

// File: tb/tb_icb_dbg_arbiter.sv
// Scoreboard bench for icb_dbg_arbiter: directed stimulus pushes expected slave commands and
// per-master responses into queues; a negedge monitor pops and compares on every handshake.
module tb_icb_dbg_arbiter;

  logic        clk, rstn;
  logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
  logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
  logic [31:0] m0_cmd_addr, m0_cmd_wdata, m0_rsp_rdata, m1_cmd_addr, m1_cmd_wdata, m1_rsp_rdata;
  logic [3:0]  m0_cmd_wmask, m1_cmd_wmask, s_cmd_wmask;
  logic        s_cmd_valid, s_cmd_ready, s_cmd_read, s_rsp_valid, s_rsp_ready, s_rsp_err;
  logic [31:0] s_cmd_addr, s_cmd_wdata, s_rsp_rdata;
  logic        arb_busy;

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_rsp0[$];
  logic [31:0] exp_rsp1[$];
  int          n_checks = 0;
  int          n_errors = 0;

  icb_dbg_arbiter #(
    .AW         (32),
    .DW         (32),
    .OUTS_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m0_cmd_valid (m0_cmd_valid),
    .m0_cmd_ready (m0_cmd_ready),
    .m0_cmd_addr  (m0_cmd_addr),
    .m0_cmd_wdata (m0_cmd_wdata),
    .m0_cmd_read  (m0_cmd_read),
    .m0_cmd_wmask (m0_cmd_wmask),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_ready (m0_rsp_ready),
    .m0_rsp_rdata (m0_rsp_rdata),
    .m0_rsp_err   (m0_rsp_err),
    .m1_cmd_valid (m1_cmd_valid),
    .m1_cmd_ready (m1_cmd_ready),
    .m1_cmd_addr  (m1_cmd_addr),
    .m1_cmd_wdata (m1_cmd_wdata),
    .m1_cmd_read  (m1_cmd_read),
    .m1_cmd_wmask (m1_cmd_wmask),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_ready (m1_rsp_ready),
    .m1_rsp_rdata (m1_rsp_rdata),
    .m1_rsp_err   (m1_rsp_err),
    .s_cmd_valid  (s_cmd_valid),
    .s_cmd_ready  (s_cmd_ready),
    .s_cmd_addr   (s_cmd_addr),
    .s_cmd_wdata  (s_cmd_wdata),
    .s_cmd_read   (s_cmd_read),
    .s_cmd_wmask  (s_cmd_wmask),
    .s_rsp_valid  (s_rsp_valid),
    .s_rsp_ready  (s_rsp_ready),
    .s_rsp_rdata  (s_rsp_rdata),
    .s_rsp_err    (s_rsp_err),
    .arb_busy     (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd0(input logic [31:0] a, input logic [31:0] d, input logic rd);
    m0_cmd_valid = 1'b1; m0_cmd_addr = a; m0_cmd_wdata = d; m0_cmd_read = rd;
    exp_cmd.push_back('{id: 1'b0, addr: a, wdata: d, rd: rd});
  endtask

  task automatic cmd1(input logic [31:0] a, input logic [31:0] d, input logic rd);
    m1_cmd_valid = 1'b1; m1_cmd_addr = a; m1_cmd_wdata = d; m1_cmd_read = rd;
    exp_cmd.push_back('{id: 1'b1, addr: a, wdata: d, rd: rd});
  endtask

  // Monitor: every command/response handshake is matched against the scoreboard queues
  always @(negedge clk) begin
    if (rstn) begin
      if (s_cmd_valid && s_cmd_ready) begin
        chk("mon_cmd_ready_onehot", 64'(m0_cmd_ready ^ m1_cmd_ready), 64'd1);
        if (exp_cmd.size() == 0) begin
          chk("mon_unexpected_cmd", 64'(s_cmd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          cmd_t e;
          e = exp_cmd.pop_front();
          chk("mon_cmd_master", 64'(m1_cmd_ready), 64'(e.id));
          chk("mon_cmd_addr", 64'(s_cmd_addr), 64'(e.addr));
          chk("mon_cmd_wdata", 64'(s_cmd_wdata), 64'(e.wdata));
          chk("mon_cmd_read", 64'(s_cmd_read), 64'(e.rd));
          chk("mon_cmd_wmask", 64'(s_cmd_wmask), e.id ? 64'h3 : 64'hF);
        end
      end
      chk("mon_rsp_valid_exclusive", 64'(m0_rsp_valid && m1_rsp_valid), 64'd0);
      if (m0_rsp_valid && m0_rsp_ready) begin
        if (exp_rsp0.size() == 0) chk("mon_unexpected_rsp_m0", 64'(m0_rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("mon_rsp_m0_rdata", 64'(m0_rsp_rdata), 64'(exp_rsp0.pop_front()));
      end
      if (m1_rsp_valid && m1_rsp_ready) begin
        if (exp_rsp1.size() == 0) chk("mon_unexpected_rsp_m1", 64'(m1_rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("mon_rsp_m1_rdata", 64'(m1_rsp_rdata), 64'(exp_rsp1.pop_front()));
      end
    end
  end

  initial begin
    rstn = 1'b0;
    m0_cmd_valid = 0; m0_cmd_addr = 0; m0_cmd_wdata = 0; m0_cmd_read = 0; m0_cmd_wmask = 4'hF;
    m1_cmd_valid = 0; m1_cmd_addr = 0; m1_cmd_wdata = 0; m1_cmd_read = 0; m1_cmd_wmask = 4'h3;
    m0_rsp_ready = 1; m1_rsp_ready = 1;
    s_cmd_ready = 0; s_rsp_valid = 0; s_rsp_rdata = 0; s_rsp_err = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_arb_busy", 64'(arb_busy), 0);
    chk("rst_s_cmd_valid", 64'(s_cmd_valid), 0);
    chk("rst_rsp_valids", 64'({m0_rsp_valid, m1_rsp_valid}), 0);
    rstn = 1'b1;
    tick();

    // 1: single core read, zero-latency pass-through, response only to m0
    s_cmd_ready = 1;
    cmd0(32'h8000_0000, 32'h0, 1'b1);
    @(negedge clk);
    chk("t1_s_cmd_addr_same_cycle", 64'(s_cmd_addr), 64'h8000_0000);
    tick(); m0_cmd_valid = 0;
    s_rsp_valid = 1; s_rsp_rdata = 32'hDEAD_BEEF; exp_rsp0.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_m1_rsp_valid", 64'(m1_rsp_valid), 0);
    chk("t1_m0_rsp_valid", 64'(m0_rsp_valid), 1);
    tick(); s_rsp_valid = 0;

    // 2: simultaneous requests, debug first, responses routed m1 then m0
    cmd1(32'h200, 32'h0, 1'b1);
    cmd0(32'h100, 32'hCAFE_0000, 1'b0);
    @(negedge clk);
    chk("t2_first_gnt_m1", 64'(m1_cmd_ready), 1);
    tick(); m1_cmd_valid = 0;
    @(negedge clk);
    chk("t2_second_gnt_m0", 64'(m0_cmd_ready), 1);
    tick(); m0_cmd_valid = 0;
    s_rsp_valid = 1; s_rsp_rdata = 32'h11; exp_rsp1.push_back(32'h11);
    tick(); s_rsp_rdata = 32'h22; exp_rsp0.push_back(32'h22);
    tick(); s_rsp_valid = 0;

    // 3: slave stall locks m0 even though m1 requests meanwhile
    s_cmd_ready = 0;
    cmd0(32'h300, 32'hA5A5_A5A5, 1'b0);
    tick();
    cmd1(32'h400, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_locked_addr", 64'(s_cmd_addr), 64'h300);
      chk("t3_m1_not_ready", 64'(m1_cmd_ready), 0);
      chk("t3_busy_while_locked", 64'(arb_busy), 1);
      tick();
    end
    s_cmd_ready = 1;
    @(negedge clk);
    chk("t3_m0_handshake", 64'(m0_cmd_ready), 1);
    tick(); m0_cmd_valid = 0;
    @(negedge clk);
    chk("t3_m1_after_m0", 64'(m1_cmd_ready), 1);
    tick(); m1_cmd_valid = 0;
    s_rsp_valid = 1; s_rsp_rdata = 32'h33; exp_rsp0.push_back(32'h33);
    tick(); s_rsp_rdata = 32'h44; exp_rsp1.push_back(32'h44);
    tick(); s_rsp_valid = 0;

    // 4: fill the ID FIFO, fifth stalls even across a same-cycle pop
    for (int i = 0; i < 4; i++) begin
      cmd0(32'h1000 + 32'(4 * i), 32'h0, 1'b1);
      tick();
    end
    cmd0(32'h2000, 32'h0, 1'b1);
    @(negedge clk);
    chk("t4_full_stall_ready", 64'(m0_cmd_ready), 0);
    chk("t4_full_stall_valid", 64'(s_cmd_valid), 0);
    tick();
    s_rsp_valid = 1; s_rsp_rdata = 32'h50; exp_rsp0.push_back(32'h50);
    @(negedge clk);
    chk("t4_stall_on_pop_cycle", 64'(m0_cmd_ready), 0);
    tick(); s_rsp_valid = 0;
    @(negedge clk);
    chk("t4_accept_after_pop", 64'(m0_cmd_ready), 1);
    tick(); m0_cmd_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      s_rsp_valid = 1; s_rsp_rdata = 32'h50 + 32'(i); exp_rsp0.push_back(32'h50 + 32'(i));
      tick();
    end
    s_rsp_valid = 0;
    @(negedge clk);
    chk("t4_idle_after_drain", 64'(arb_busy), 0);

    // 5: stalled m0 response blocks the m1 response behind it
    tick();
    cmd0(32'h500, 32'h0, 1'b1);
    tick(); m0_cmd_valid = 0;
    cmd1(32'h504, 32'h0, 1'b1);
    tick(); m1_cmd_valid = 0;
    m0_rsp_ready = 0; s_rsp_valid = 1; s_rsp_rdata = 32'h60;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_s_rsp_ready_blocked", 64'(s_rsp_ready), 0);
      chk("t5_m1_rsp_valid_blocked", 64'(m1_rsp_valid), 0);
      chk("t5_m0_rsp_valid_held", 64'(m0_rsp_valid), 1);
      tick();
    end
    m0_rsp_ready = 1; exp_rsp0.push_back(32'h60);
    @(negedge clk);
    chk("t5_s_rsp_ready_released", 64'(s_rsp_ready), 1);
    tick(); s_rsp_rdata = 32'h61; exp_rsp1.push_back(32'h61);
    @(negedge clk);
    chk("t5_m1_rsp_valid", 64'(m1_rsp_valid), 1);
    tick(); s_rsp_valid = 0;

    // 6: async reset with outstanding commands and a lock in place
    cmd0(32'h600, 32'h0, 1'b1);
    tick();
    m0_cmd_addr = 32'h604; exp_cmd.push_back('{id: 1'b0, addr: 32'h604, wdata: 32'h0, rd: 1'b1});
    tick(); m0_cmd_valid = 0;
    s_cmd_ready = 0; m1_cmd_valid = 1; m1_cmd_addr = 32'h608; m1_cmd_read = 1;
    tick();
    @(negedge clk);
    chk("t6_busy_before_reset", 64'(arb_busy), 1);
    #2;
    rstn = 0; m1_cmd_valid = 0;
    #1;
    chk("t6_busy_cleared_async", 64'(arb_busy), 0);
    tick();
    chk("t6_busy_after_edge", 64'(arb_busy), 0);
    chk("t6_s_cmd_valid", 64'(s_cmd_valid), 0);
    chk("t6_rsp_valids", 64'({m0_rsp_valid, m1_rsp_valid}), 0);
    rstn = 1;
    s_rsp_valid = 1; s_rsp_rdata = 32'h77;
    @(negedge clk);
    chk("t6_stray_rsp_not_accepted", 64'(s_rsp_ready), 0);
    chk("t6_stray_rsp_no_valid", 64'({m0_rsp_valid, m1_rsp_valid}), 0);
    tick(); s_rsp_valid = 0;
    tick();

    chk("end_cmd_queue_empty", 64'(exp_cmd.size()), 0);
    chk("end_rsp0_queue_empty", 64'(exp_rsp0.size()), 0);
    chk("end_rsp1_queue_empty", 64'(exp_rsp1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
